alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 203 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, plus iterative shift-add
// multiply and restoring divide/remainder that take WIDTH cycles each.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic             is_zero,
  output logic             is_negative,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  typedef enum logic [1:0] {K_MUL = 2'd0, K_DIV = 2'd1, K_REM = 2'd2} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             co_q, co_d;
  logic             zero_q, neg_q;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sc_c;
  logic             sc_co;
  logic             is_multi;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rsh;
  logic [WIDTH:0]   div_diff;

  // Handshake: start/op/a/b/carry_in are sampled on a rising edge only while
  // busy=0; done is a one-cycle pulse marking c/flags as freshly written, and
  // a new start may be presented during that same cycle.

  assign is_multi = (op == 8'd9) || (op == 8'd10) || (op == 8'd11);

  always_comb begin
    sc_c  = '0;
    sc_co = 1'b0;
    case (op)
      8'd0: {sc_co, sc_c} = {1'b0, a} + {1'b0, b};
      8'd1: {sc_co, sc_c} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
      8'd2: {sc_co, sc_c} = {1'b0, a} - {1'b0, b};
      8'd3: {sc_co, sc_c} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
      8'd4: sc_c = a | b;
      8'd5: sc_c = a & b;
      8'd6: sc_c = ~a;
      8'd7: sc_c = a ^ b;
      8'd8: begin
        if (a < b) begin
          sc_c  = '1;
          sc_co = 1'b1;
        end else if (a == b) begin
          sc_c = '0;
        end else begin
          sc_c = {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      8'd12: begin
        sc_c  = {a[WIDTH-2:0], 1'b0};
        sc_co = a[WIDTH-1];
      end
      8'd13: begin
        sc_c  = {1'b0, a[WIDTH-1:1]};
        sc_co = a[0];
      end
      default: begin
        sc_c  = '0;
        sc_co = 1'b0;
      end
    endcase
  end

  // hi holds the running product-high / partial remainder; lo holds the
  // multiplier / dividend-quotient shift register.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_rsh  = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_rsh - {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    bz_d    = bz_q;
    c_d     = c_q;
    co_d    = co_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multi) begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH);
            hi_d    = '0;
            bz_d    = (b == '0);
            if (op == 8'd9) begin
              kind_d = K_MUL;
              lo_d   = b;
              opnd_d = a;
            end else begin
              kind_d = (op == 8'd10) ? K_DIV : K_REM;
              lo_d   = a;
              opnd_d = b;
            end
          end else begin
            c_d    = sc_c;
            co_d   = sc_co;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (kind_q == K_MUL) begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_rsh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          case (kind_q)
            K_MUL: begin
              c_d  = lo_d;
              co_d = (hi_d != '0);
            end
            K_DIV: begin
              c_d  = lo_d;
              co_d = bz_q;
            end
            default: begin
              c_d  = hi_d;
              co_d = bz_q;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      kind_q  <= K_MUL;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      bz_q    <= 1'b0;
      c_q     <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      bz_q    <= bz_d;
      c_q     <= c_d;
      co_q    <= co_d;
      zero_q  <= (c_d == '0);
      neg_q   <= c_d[WIDTH-1];
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign c           = c_q;
  assign carry_out   = co_q;
  assign is_zero     = zero_q;
  assign is_negative = neg_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed vector table, random ops against an
// arithmetic reference model, and hand-written abort/reset sequences.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [7:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic         carry_out;
  logic         is_zero;
  logic         is_negative;
  logic         state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] last_c;

  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_c;
    logic         exp_co;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .carry_in(carry_in), .busy(busy), .done(done), .c(c),
    .carry_out(carry_out), .is_zero(is_zero), .is_negative(is_negative),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic on wide integers.
  function automatic void model(input logic [7:0] mop, input logic [W-1:0] ma,
                                input logic [W-1:0] mb, input logic mcin,
                                output logic [W-1:0] mc, output logic mco);
    longint unsigned la, lb, lc, p;
    la = ma; lb = mb; lc = mcin;
    mc = '0; mco = 1'b0;
    case (mop)
      8'd0: begin p = la + lb; mc = p[W-1:0]; mco = p[W]; end
      8'd1: begin p = la + lb + lc; mc = p[W-1:0]; mco = p[W]; end
      8'd2: begin mc = W'(la - lb); mco = (la < lb); end
      8'd3: begin mc = W'(la - lb - lc); mco = (la < lb + lc); end
      8'd4: mc = ma | mb;
      8'd5: mc = ma & mb;
      8'd6: mc = ~ma;
      8'd7: mc = ma ^ mb;
      8'd8: begin
        if (la < lb) begin mc = '1; mco = 1'b1; end
        else if (la == lb) mc = '0;
        else mc = 1;
      end
      8'd9: begin p = la * lb; mc = p[W-1:0]; mco = (p[63:W] != 0); end
      8'd10: begin
        if (lb == 0) begin mc = '1; mco = 1'b1; end
        else mc = W'(la / lb);
      end
      8'd11: begin
        if (lb == 0) begin mc = ma; mco = 1'b1; end
        else mc = W'(la % lb);
      end
      8'd12: begin p = la * 2; mc = p[W-1:0]; mco = p[W]; end
      8'd13: begin mc = W'(la / 2); mco = ma[0]; end
      default: begin mc = '0; mco = 1'b0; end
    endcase
  endfunction

  // Driver: called at a negedge; presents start immediately and returns at
  // the negedge where done is seen, so a following call issues back-to-back.
  task automatic run_op(input string name, input logic [7:0] vop,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic [W-1:0] ec, input logic eco);
    int lat;
    int busy_cnt;
    int exp_lat;
    logic [W:0] e;
    exp_q.push_back({eco, ec});
    exp_lat = (vop == 8'd9 || vop == 8'd10 || vop == 8'd11) ? W : 0;
    start = 1'b1; op = vop; a = va; b = vb; carry_in = vcin;
    @(negedge clk);
    start = 1'b0; op = $urandom; a = $urandom; b = $urandom; carry_in = $urandom;
    lat = 0; busy_cnt = 0;
    while (!done && lat < W + 4) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, busy_cnt, exp_lat);
    chk({name, "_busy_at_done"}, busy, 1'b0);
    e = exp_q.pop_front();
    chk({name, "_c"}, c, e[W-1:0]);
    chk({name, "_carry_out"}, carry_out, e[W]);
    chk({name, "_is_zero"}, is_zero, (e[W-1:0] == '0));
    chk({name, "_is_negative"}, is_negative, e[W-1]);
    last_c = e[W-1:0];
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("hold_c", c, last_c);
      chk("no_done_idle", done, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] mc;
    logic         mco;
    logic [7:0]   rop;
    logic [W-1:0] ra, rb;
    int           done_seen;

    vecs[0]  = '{8'd1,  32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[1]  = '{8'd9,  32'h00010000, 32'h00010000, 1'b0, 32'h0,        1'b1};
    vecs[2]  = '{8'd9,  32'h7,        32'h6,        1'b0, 32'h2A,       1'b0};
    vecs[3]  = '{8'd10, 32'h64,       32'h7,        1'b0, 32'hE,        1'b0};
    vecs[4]  = '{8'd11, 32'h64,       32'h7,        1'b0, 32'h2,        1'b0};
    vecs[5]  = '{8'd10, 32'h5,        32'h0,        1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{8'd11, 32'h5,        32'h0,        1'b0, 32'h5,        1'b1};
    vecs[7]  = '{8'd8,  32'h3,        32'h5,        1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{8'd8,  32'h5,        32'h5,        1'b0, 32'h0,        1'b0};
    vecs[9]  = '{8'd8,  32'h5,        32'h3,        1'b0, 32'h1,        1'b0};
    vecs[10] = '{8'd0,  32'h1,        32'h2,        1'b1, 32'h3,        1'b0};
    vecs[11] = '{8'd2,  32'h3,        32'h5,        1'b0, 32'hFFFFFFFE, 1'b1};
    vecs[12] = '{8'd3,  32'h5,        32'h3,        1'b1, 32'h1,        1'b0};
    vecs[13] = '{8'd4,  32'hF0,       32'h0F,       1'b0, 32'hFF,       1'b0};
    vecs[14] = '{8'd5,  32'hF0,       32'h3C,       1'b0, 32'h30,       1'b0};
    vecs[15] = '{8'd6,  32'h0,        32'h1234,     1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[16] = '{8'd7,  32'hFF,       32'h0F,       1'b0, 32'hF0,       1'b0};
    vecs[17] = '{8'd12, 32'h80000001, 32'h0,        1'b0, 32'h2,        1'b1};
    vecs[18] = '{8'd13, 32'h80000001, 32'h0,        1'b0, 32'h40000000, 1'b1};
    vecs[19] = '{8'd200, 32'h5,       32'h6,        1'b1, 32'h0,        1'b0};
    vecs[20] = '{8'd14, 32'hFFFF,     32'h1,        1'b0, 32'h0,        1'b0};
    vecs[21] = '{8'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1,        1'b1};

    resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
    last_c = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_c", c, '0);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_zero", is_zero, 1'b1);
    chk("reset_neg", is_negative, 1'b0);
    chk("reset_state", state_dbg, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_c, vecs[i].exp_co);
      if (i % 3 == 0) idle_check(2);
    end

    // start during RUN is ignored; then back-to-back issue on the done cycle
    exp_q.push_back({1'b0, 32'hE});
    start = 1'b1; op = 8'd10; a = 32'h64; b = 32'h7; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 8'd0; a = 32'h1; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      logic [W:0] e;
      n = 6;
      while (!done && n < W + 6) begin
        @(negedge clk);
        n++;
      end
      chk("ignore_latency", n, W + 1);
      e = exp_q.pop_front();
      chk("ignore_c", c, e[W-1:0]);
      chk("ignore_carry", carry_out, e[W]);
      last_c = e[W-1:0];
    end
    run_op("b2b_add", 8'd0, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0);
    run_op("b2b_mul", 8'd9, 32'h3, 32'h5, 1'b0, 32'hF, 1'b0);
    idle_check(2);

    // reset mid-multiply
    start = 1'b1; op = 8'd9; a = 32'h12345; b = 32'h6789;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_c", c, '0);
    chk("abort_zero", is_zero, 1'b1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    done_seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    chk("abort_no_done", done_seen, 0);
    last_c = '0;
    run_op("after_reset", 8'd9, 32'h7, 32'h6, 1'b0, 32'h2A, 1'b0);

    // randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      rop = 8'($urandom_range(0, 15));
      if (rop == 8'd15) rop = 8'($urandom_range(14, 255));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      model(rop, ra, rb, 1'($urandom_range(0, 1)), mc, mco);
      carry_in = 1'b0;
      begin
        logic rc;
        rc = 1'($urandom_range(0, 1));
        model(rop, ra, rb, rc, mc, mco);
        run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rc, mc, mco);
      end
      if ($urandom_range(0, 2) == 0) idle_check($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
